// File: rtl/pwm_timer_pkg.sv
// Shared definitions for the multi-channel PWM timer: channel FSM states,
// config register select codes and CTRL field positions.
package pwm_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } chan_state_e;

    typedef enum logic [1:0] {
        SEL_LOW  = 2'd0,
        SEL_HIGH = 2'd1,
        SEL_CTRL = 2'd2,
        SEL_RSVD = 2'd3
    } cfg_sel_e;

    // CTRL layout: pulse count N in the low bits, mode bit just above it.
    localparam int CTRL_N_LSB = 0;

    function automatic int ctrl_mode_bit(input int puls_w);
        return CTRL_N_LSB + puls_w;
    endfunction

endpackage

// File: rtl/pwm_timer_chan.sv
// One PWM timer channel: shadow/active period registers, a phase counter,
// a pulse counter and the IDLE/LOW/HIGH/DONE sequencer.
module pwm_timer_chan
    import pwm_timer_pkg::*;
#(
    parameter int CTSW_DWIDTH   = 24,
    parameter int C_PULS_DWIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_low,
    input  logic                   i_wr_high,
    input  logic                   i_wr_ctrl,
    input  logic [CTSW_DWIDTH-1:0] i_wdata,
    input  logic                   i_start,
    input  logic                   i_stop,
    output logic                   o_pwm,
    output logic                   o_done,
    output logic                   o_busy
);

    localparam int MODE_BIT = ctrl_mode_bit(C_PULS_DWIDTH);

    typedef logic [CTSW_DWIDTH-1:0]   per_t;
    typedef logic [C_PULS_DWIDTH-1:0] puls_t;

    chan_state_e r_state, w_state_nx;

    per_t  r_sh_low, r_sh_high, r_act_low, r_act_high, r_phase_cnt;
    puls_t r_sh_n, r_act_n, r_puls_cnt;
    logic  r_sh_mode, r_act_mode;
    logic  r_pwm, r_done, r_busy;

    per_t  w_byp_low, w_byp_high, w_low_last, w_high_last;
    puls_t w_byp_n, w_puls_nx, w_n_eff;
    logic  w_byp_mode, w_oneshot_done;
    logic  w_load, w_reload, w_phase_clr;

    // A write landing in the same cycle as a load must be seen by that load.
    assign w_byp_low  = i_wr_low  ? i_wdata : r_sh_low;
    assign w_byp_high = i_wr_high ? i_wdata : r_sh_high;
    assign w_byp_n    = i_wr_ctrl ? i_wdata[CTRL_N_LSB +: C_PULS_DWIDTH] : r_sh_n;
    assign w_byp_mode = i_wr_ctrl ? i_wdata[MODE_BIT] : r_sh_mode;

    assign w_low_last     = (r_act_low  == '0) ? '0 : r_act_low  - per_t'(1);
    assign w_high_last    = (r_act_high == '0) ? '0 : r_act_high - per_t'(1);
    assign w_puls_nx      = r_puls_cnt + puls_t'(1);
    assign w_n_eff        = (r_act_n == '0) ? puls_t'(1) : r_act_n;
    assign w_oneshot_done = !r_act_mode && (w_puls_nx >= w_n_eff);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nx;
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nx  = r_state;
        w_load      = 1'b0;
        w_reload    = 1'b0;
        w_phase_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    w_state_nx  = ST_LOW;
                    w_load      = 1'b1;
                    w_phase_clr = 1'b1;
                end
            end
            ST_LOW: begin
                if (i_stop) begin
                    w_state_nx = ST_IDLE;
                end else if (r_phase_cnt == w_low_last) begin
                    w_state_nx  = ST_HIGH;
                    w_phase_clr = 1'b1;
                end
            end
            ST_HIGH: begin
                if (i_stop) begin
                    w_state_nx = ST_IDLE;
                end else if (r_phase_cnt == w_high_last) begin
                    w_phase_clr = 1'b1;
                    if (w_oneshot_done) begin
                        w_state_nx = ST_DONE;
                    end else begin
                        w_state_nx = ST_LOW;
                        w_reload   = 1'b1;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // NOTE: the shadow and active registers are few and architecturally
    // visible after reset, so they are reset like any other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_low    <= '0;
            r_sh_high   <= '0;
            r_sh_n      <= '0;
            r_sh_mode   <= 1'b0;
            r_act_low   <= '0;
            r_act_high  <= '0;
            r_act_n     <= '0;
            r_act_mode  <= 1'b0;
            r_phase_cnt <= '0;
            r_puls_cnt  <= '0;
            r_pwm       <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sh_low  <= w_byp_low;
            r_sh_high <= w_byp_high;
            r_sh_n    <= w_byp_n;
            r_sh_mode <= w_byp_mode;

            if (w_load || w_reload) begin
                r_act_low  <= w_byp_low;
                r_act_high <= w_byp_high;
                r_act_n    <= w_byp_n;
                r_act_mode <= w_byp_mode;
            end

            if (w_load)        r_puls_cnt <= '0;
            else if (w_reload) r_puls_cnt <= w_puls_nx;

            if (w_phase_clr)
                r_phase_cnt <= '0;
            else if (r_state == ST_LOW || r_state == ST_HIGH)
                r_phase_cnt <= r_phase_cnt + per_t'(1);

            // Outputs are registered from the next state so they align with r_state.
            r_pwm  <= (w_state_nx == ST_HIGH);
            r_done <= (w_state_nx == ST_DONE);
            r_busy <= (w_state_nx != ST_IDLE);
        end
    end

    assign o_pwm  = r_pwm;
    assign o_done = r_done;
    assign o_busy = r_busy;

endmodule

// File: rtl/pwm_timer_mc.sv
// Multi-channel PWM timer top: decodes the config port into per-channel
// register write strobes and instantiates one independent channel each.
module pwm_timer_mc
    import pwm_timer_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int CTSW_DWIDTH   = 24,
    parameter int C_PULS_DWIDTH = 4,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we_i,
    input  logic [CH_W-1:0]        cfg_ch_i,
    input  logic [1:0]             cfg_sel_i,
    input  logic [CTSW_DWIDTH-1:0] cfg_wdata_i,
    input  logic [NUM_CH-1:0]      start_i,
    input  logic [NUM_CH-1:0]      stop_i,
    output logic [NUM_CH-1:0]      pwm_o,
    output logic [NUM_CH-1:0]      done_o,
    output logic [NUM_CH-1:0]      busy_o
);

    logic w_we_low, w_we_high, w_we_ctrl;

    // The reserved select decodes to no strobe at all.
    assign w_we_low  = cfg_we_i && (cfg_sel_i == SEL_LOW);
    assign w_we_high = cfg_we_i && (cfg_sel_i == SEL_HIGH);
    assign w_we_ctrl = cfg_we_i && (cfg_sel_i == SEL_CTRL);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        logic w_hit;
        assign w_hit = (cfg_ch_i == CH_W'(g));

        pwm_timer_chan #(
            .CTSW_DWIDTH  (CTSW_DWIDTH),
            .C_PULS_DWIDTH(C_PULS_DWIDTH)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .i_wr_low (w_we_low  && w_hit),
            .i_wr_high(w_we_high && w_hit),
            .i_wr_ctrl(w_we_ctrl && w_hit),
            .i_wdata  (cfg_wdata_i),
            .i_start  (start_i[g]),
            .i_stop   (stop_i[g]),
            .o_pwm    (pwm_o[g]),
            .o_done   (done_o[g]),
            .o_busy   (busy_o[g])
        );
    end

endmodule

// File: tb/tb_pwm_timer_mc.sv
// Self-checking bench for pwm_timer_mc: directed scenarios plus random
// traffic, compared every cycle against a phase-end-time reference model.
module tb_pwm_timer_mc;

    localparam int NUM_CH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we_i = 1'b0;
    logic [1:0]  cfg_ch_i = '0;
    logic [1:0]  cfg_sel_i = '0;
    logic [23:0] cfg_wdata_i = '0;
    logic [3:0]  start_i = '0;
    logic [3:0]  stop_i = '0;
    logic [3:0]  pwm_o, done_o, busy_o;

    always #5 clk = ~clk;

    pwm_timer_mc #(.NUM_CH(4), .CTSW_DWIDTH(24), .C_PULS_DWIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we_i   (cfg_we_i),
        .cfg_ch_i   (cfg_ch_i),
        .cfg_sel_i  (cfg_sel_i),
        .cfg_wdata_i(cfg_wdata_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .pwm_o      (pwm_o),
        .done_o     (done_o),
        .busy_o     (busy_o)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: each busy channel remembers the edge at which its
    // current phase ends, computed as start edge + max(P,1).
    typedef enum {M_IDLE, M_LOW, M_HIGH, M_DONE} mphase_e;
    mphase_e m_ph[NUM_CH];
    int m_end[NUM_CH], m_cnt[NUM_CH];
    int sh_low[NUM_CH], sh_high[NUM_CH], sh_ctrl[NUM_CH];
    int a_low[NUM_CH], a_high[NUM_CH], a_ctrl[NUM_CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int eff(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_ph[c] = M_IDLE; m_end[c] = 0; m_cnt[c] = 0;
            sh_low[c] = 0; sh_high[c] = 0; sh_ctrl[c] = 0;
            a_low[c] = 0; a_high[c] = 0; a_ctrl[c] = 0;
        end
    endfunction

    function automatic void model_step(input bit we, input int wch, input int sel, input int wd,
                                       input bit [3:0] st, input bit [3:0] sp);
        for (int c = 0; c < NUM_CH; c++) begin
            int sl = sh_low[c], shh = sh_high[c], sc = sh_ctrl[c];
            if (we && wch == c) begin
                if (sel == 0) sl = wd & 'hFFFFFF;
                else if (sel == 1) shh = wd & 'hFFFFFF;
                else if (sel == 2) sc = wd & 'h1F;
            end
            if (m_ph[c] == M_IDLE) begin
                if (st[c] && !sp[c]) begin
                    a_low[c] = sl; a_high[c] = shh; a_ctrl[c] = sc;
                    m_cnt[c] = 0;
                    m_ph[c] = M_LOW;
                    m_end[c] = cyc + eff(sl);
                end
            end else if (m_ph[c] == M_DONE || sp[c]) begin
                m_ph[c] = M_IDLE;
            end else if (cyc == m_end[c]) begin
                if (m_ph[c] == M_LOW) begin
                    m_ph[c] = M_HIGH;
                    m_end[c] = cyc + eff(a_high[c]);
                end else begin
                    int n = a_ctrl[c] & 15;
                    m_cnt[c] = (m_cnt[c] + 1) % 16;
                    if (((a_ctrl[c] >> 4) & 1) == 0 && m_cnt[c] >= ((n == 0) ? 1 : n)) begin
                        m_ph[c] = M_DONE;
                    end else begin
                        a_low[c] = sl; a_high[c] = shh; a_ctrl[c] = sc;
                        m_ph[c] = M_LOW;
                        m_end[c] = cyc + eff(sl);
                    end
                end
            end
            sh_low[c] = sl; sh_high[c] = shh; sh_ctrl[c] = sc;
        end
    endfunction

    task automatic tick(input bit we, input int wch, input int sel, input int wd,
                        input bit [3:0] st, input bit [3:0] sp);
        cfg_we_i = we; cfg_ch_i = wch[1:0]; cfg_sel_i = sel[1:0];
        cfg_wdata_i = wd[23:0]; start_i = st; stop_i = sp;
        @(posedge clk);
        cyc++;
        model_step(we, wch, sel, wd, st, sp);
        @(negedge clk);
        cfg_we_i = 1'b0; start_i = '0; stop_i = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("pwm[%0d]", c),  32'(pwm_o[c]),  32'(m_ph[c] == M_HIGH));
            check($sformatf("done[%0d]", c), 32'(done_o[c]), 32'(m_ph[c] == M_DONE));
            check($sformatf("busy[%0d]", c), 32'(busy_o[c]), 32'(m_ph[c] != M_IDLE));
        end
    endtask

    task automatic idle();
        tick(1'b0, 0, 0, 0, 4'b0, 4'b0);
    endtask

    task automatic cfg(input int c, input int sel, input int val);
        tick(1'b1, c, sel, val, 4'b0, 4'b0);
    endtask

    // Idle-ticks until pwm_o[c] reaches lvl; n returns the ticks taken.
    task automatic wait_pwm(input int c, input bit lvl, input int limit, output int n);
        n = 0;
        while (pwm_o[c] !== lvl && n < limit) begin
            idle();
            n++;
        end
        if (pwm_o[c] !== lvl) check($sformatf("timeout_pwm[%0d]", c), 32'(pwm_o[c]), 32'(lvl));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] o_pwm12, o_done12, o_busy12;
        logic [3:0]  o_pwm4, o_done4, o_busy4;
        int n, len1, len2;
        int first_hi[NUM_CH];

        model_reset();
        repeat (2) @(negedge clk);
        check("rst_pwm",  32'(pwm_o),  32'(0));
        check("rst_done", 32'(done_o), 32'(0));
        check("rst_busy", 32'(busy_o), 32'(0));
        rst = 1'b0;
        idle();

        // Two-pulse one-shot with explicit timing.
        cfg(0, 0, 3); cfg(0, 1, 2); cfg(0, 2, 2);
        tick(1'b0, 0, 0, 0, 4'b0001, 4'b0);
        o_pwm12[0] = pwm_o[0]; o_done12[0] = done_o[0]; o_busy12[0] = busy_o[0];
        for (int i = 1; i < 12; i++) begin
            idle();
            o_pwm12[i] = pwm_o[0]; o_done12[i] = done_o[0]; o_busy12[i] = busy_o[0];
        end
        check("seq2_pwm",  32'(o_pwm12),  32'(12'b001100011000));
        check("seq2_done", 32'(o_done12), 32'(12'b010000000000));
        check("seq2_busy", 32'(o_busy12), 32'(12'b011111111111));

        // Zero periods collapse to one-cycle phases.
        cfg(0, 0, 0); cfg(0, 1, 0); cfg(0, 2, 1);
        tick(1'b0, 0, 0, 0, 4'b0001, 4'b0);
        o_pwm4[0] = pwm_o[0]; o_done4[0] = done_o[0]; o_busy4[0] = busy_o[0];
        for (int i = 1; i < 4; i++) begin
            idle();
            o_pwm4[i] = pwm_o[0]; o_done4[i] = done_o[0]; o_busy4[i] = busy_o[0];
        end
        check("zero_pwm",  32'(o_pwm4),  32'(4'b0010));
        check("zero_done", 32'(o_done4), 32'(4'b0100));
        check("zero_busy", 32'(o_busy4), 32'(4'b0111));

        // Continuous channel aborted during its second HIGH.
        cfg(1, 0, 300); cfg(1, 1, 1); cfg(1, 2, 16);
        tick(1'b0, 0, 0, 0, 4'b0010, 4'b0);
        wait_pwm(1, 1'b1, 400, n);
        wait_pwm(1, 1'b0, 10, n);
        wait_pwm(1, 1'b1, 400, n);
        tick(1'b0, 0, 0, 0, 4'b0, 4'b0010);
        check("stop_pwm1",  32'(pwm_o[1]),  32'(0));
        check("stop_done1", 32'(done_o[1]), 32'(0));
        check("stop_busy1", 32'(busy_o[1]), 32'(0));
        repeat (3) idle();

        // HIGH rewritten mid-LOW only affects the following pulse.
        cfg(2, 0, 5); cfg(2, 1, 5); cfg(2, 2, 16);
        tick(1'b0, 0, 0, 0, 4'b0100, 4'b0);
        idle(); idle();
        cfg(2, 1, 10);
        wait_pwm(2, 1'b1, 20, n);
        wait_pwm(2, 1'b0, 30, len1);
        check("shadow_high_cur", 32'(len1), 32'(5));
        wait_pwm(2, 1'b1, 20, n);
        wait_pwm(2, 1'b0, 30, len2);
        check("shadow_high_next", 32'(len2), 32'(10));
        tick(1'b0, 0, 0, 0, 4'b0, 4'b0100);

        // Simultaneous start and stop leaves the channel idle.
        tick(1'b0, 0, 0, 0, 4'b1000, 4'b1000);
        check("start_stop_busy3", 32'(busy_o[3]), 32'(0));

        // All channels started together with distinct periods.
        for (int c = 0; c < NUM_CH; c++) begin
            cfg(c, 0, c + 1); cfg(c, 1, c + 2); cfg(c, 2, 1);
            first_hi[c] = -1;
        end
        tick(1'b0, 0, 0, 0, 4'b1111, 4'b0);
        for (int i = 1; i < 20; i++) begin
            idle();
            for (int c = 0; c < NUM_CH; c++)
                if (pwm_o[c] && first_hi[c] < 0) first_hi[c] = i;
        end
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("multi_rise[%0d]", c), 32'(first_hi[c]), 32'(c + 1));

        // Asynchronous reset in the middle of a HIGH phase.
        cfg(0, 0, 1); cfg(0, 1, 20); cfg(0, 2, 1);
        tick(1'b0, 0, 0, 0, 4'b0001, 4'b0);
        wait_pwm(0, 1'b1, 10, n);
        idle(); idle();
        #1 rst = 1'b1;
        #1;
        check("async_rst_pwm",  32'(pwm_o),  32'(0));
        check("async_rst_busy", 32'(busy_o), 32'(0));
        check("async_rst_done", 32'(done_o), 32'(0));
        rst = 1'b0;
        model_reset();
        idle();

        // Random traffic: writes (incl. reserved and write-with-start), starts, stops.
        for (int it = 0; it < 3000; it++) begin
            bit we;
            int wch, sel, wd;
            bit [3:0] st, sp;
            we  = ($urandom_range(0, 3) == 0);
            wch = $urandom_range(0, 3);
            sel = $urandom_range(0, 3);
            if (sel == 2) wd = $urandom_range(0, 31) | ($urandom_range(0, 255) << 8);
            else          wd = $urandom_range(0, 7);
            for (int c = 0; c < NUM_CH; c++) begin
                st[c] = ($urandom_range(0, 7) == 0);
                sp[c] = ($urandom_range(0, 47) == 0);
            end
            tick(we, wch, sel, wd, st, sp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_timer_mc.md
PWM_TIMER_MC -- requirements
Module: pwm_timer_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of independent timer channels (1..16).
REQ-002 SHALL have parameter CTSW_DWIDTH, default 24, meaning width of the low- and high-phase period counters.
REQ-003 SHALL have parameter C_PULS_DWIDTH, default 4, meaning width of the per-channel pulse-count field; CTSW_DWIDTH > C_PULS_DWIDTH.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset; asynchronous, active-high.
REQ-006 SHALL have port cfg_we_i, input, 1, meaning config write strobe.
REQ-007 SHALL have port cfg_ch_i, input, clog2(NUM_CH) (min 1), meaning target channel.
REQ-008 SHALL have port cfg_sel_i, input, 2, meaning register select: 0=LOW period, 1=HIGH period, 2=CTRL, 3=reserved (write ignored).
REQ-009 SHALL have port cfg_wdata_i, input, CTSW_DWIDTH, meaning write data; CTRL uses [C_PULS_DWIDTH-1:0]=pulse count N, bit [C_PULS_DWIDTH]=mode (0 one-shot, 1 continuous).
REQ-010 SHALL have port start_i, input, NUM_CH, meaning per-channel start pulse.
REQ-011 SHALL have port stop_i, input, NUM_CH, meaning per-channel abort pulse.
REQ-012 SHALL have port pwm_o, output, NUM_CH, meaning registered pulse output.
REQ-013 SHALL have port done_o, output, NUM_CH, meaning one-cycle completion strobe.
REQ-014 SHALL have port busy_o, output, NUM_CH, meaning channel not in IDLE.

Function
REQ-015 Each channel SHALL hold shadow registers LOW, HIGH, CTRL (written by cfg port, any time) and active copies used by the counters.
REQ-016 Each channel SHALL run FSM IDLE -> LOW -> HIGH -> (LOW | DONE) -> IDLE.
REQ-017 IDLE + start_i: active copies SHALL be loaded from shadows, pulse counter cleared, state -> LOW next cycle.
REQ-018 Phase length SHALL be max(P,1) cycles for period value P; pwm_o=0 in LOW, 1 in HIGH.
REQ-019 Start at edge t SHALL give pwm_o low for cycles t+1..t+L and high for t+L+1..t+L+H (L,H effective lengths).
REQ-020 End of HIGH: pulse counter increments; one-shot with count reaching max(N,1) -> DONE; otherwise -> LOW with active LOW/HIGH/CTRL reloaded from shadows.
REQ-021 DONE SHALL last exactly one cycle with done_o=1, pwm_o=0, then IDLE.
REQ-022 Continuous mode SHALL never reach DONE; only stop_i or rst ends it.
REQ-023 stop_i in any non-IDLE state SHALL force IDLE next cycle, pwm_o=0, no done_o.
REQ-024 start_i and stop_i same cycle: stop SHALL win; channel stays/returns IDLE.
REQ-025 start_i while busy SHALL be ignored.
REQ-026 Config write same cycle as start_i on the same channel SHALL be visible in the loaded active copy (write-through bypass).
REQ-027 Shadow writes while busy SHALL take effect only at the next pulse boundary (REQ-020), never mid-phase.
REQ-028 Pulse counter SHALL be C_PULS_DWIDTH wide; N=0 in one-shot means one pulse.
REQ-029 Channels SHALL be fully independent; no shared counters.

Reset
REQ-030 rst SHALL asynchronously force all FSMs to IDLE, counters to 0, pwm_o=0, done_o=0, busy_o=0.
REQ-031 Shadow LOW/HIGH SHALL reset to 0, CTRL to 0 (one-shot, N=0); reset mid-pulse SHALL drop pwm_o immediately.

Structure
REQ-032 Package pwm_timer_pkg SHALL hold FSM state encoding, cfg_sel codes, CTRL bit positions.
REQ-033 Per-channel logic SHALL be sub-module pwm_timer_chan, instantiated NUM_CH times by generate; top holds only cfg decode.

Verification
REQ-034 Ch0 LOW=3, HIGH=2, CTRL N=2 one-shot, start at t -> pwm_o 0 t+1..t+3, 1 t+4..t+5, 0 t+6..t+8, 1 t+9..t+10; done_o at t+11; busy_o 0 at t+12.
REQ-035 LOW=0, HIGH=0, N=1 start -> pwm_o 0 one cycle, 1 one cycle, done_o next cycle.
REQ-036 Ch1 continuous LOW=300, HIGH=1; stop_i at 2nd HIGH -> pwm_o 0 next cycle, no done_o, busy_o 0.
REQ-037 Ch2 running LOW=5 HIGH=5; write HIGH=10 mid-LOW -> current pulse high 5 cycles, next pulse high 10.
REQ-038 start_i and stop_i together on ch3 -> busy_o stays 0; rst asserted mid-HIGH on ch0 -> pwm_o 0 without clock edge.
REQ-039 All 4 channels started same cycle with different periods -> each matches its own REQ-019 timing.
